// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : micro_sequencer
// Brief    : Micro-address sequencer (WAIT/EVAL/HALT) for a registered micro-ROM.
//            Optional committed-microword counter under MICRO_SEQ_PERF_EN.
// Revision : 1.0
// ============================================================================
module micro_sequencer #(
  parameter logic [5:0] RESET_ADDR    = 6'd0,
  parameter logic [5:0] FETCH_ADDR    = 6'd1,
  parameter logic [5:0] DISPATCH_BASE = 6'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  next_addr,
  input  logic [1:0]  br_sel,
  input  logic        cond_flag,
  input  logic [3:0]  ir_op,
  input  logic        ir_valid,
  input  logic        mem_wait,
  input  logic        halt_req,
  output logic [5:0]  micro_addr,
  output logic        op_fire,
  output logic        ir_ack,
  output logic        stall,
  output logic        halted,
  output logic [15:0] ucycle_cnt
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_EVAL = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [1:0] c_BR_JMP  = 2'b00;
  localparam logic [1:0] c_BR_DISP = 2'b01;
  localparam logic [1:0] c_BR_COND = 2'b10;

  state_t     r_state;
  state_t     w_state_next;
  logic [5:0] r_micro_addr;
  logic [5:0] w_addr_next;
  logic [5:0] w_target;
  logic       r_halted;
  logic       w_fire;
  logic       w_stall;
  logic       w_ack;

  always_comb begin
    case (br_sel)
      c_BR_JMP:  w_target = next_addr;
      c_BR_DISP: w_target = DISPATCH_BASE + {2'b00, ir_op};
      c_BR_COND: w_target = cond_flag ? next_addr : r_micro_addr + 6'd1;
      default:   w_target = FETCH_ADDR;
    endcase
  end

  // A stalled word never commits, so halt_req only matters once it fires.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_micro_addr;
    w_fire       = 1'b0;
    w_stall      = 1'b0;
    w_ack        = 1'b0;
    case (r_state)
      ST_WAIT: w_state_next = ST_EVAL;
      ST_EVAL: begin
        if (mem_wait || (br_sel == c_BR_DISP && !ir_valid)) begin
          w_stall = 1'b1;
        end else begin
          w_fire       = 1'b1;
          w_ack        = (br_sel == c_BR_DISP);
          w_addr_next  = w_target;
          w_state_next = halt_req ? ST_HALT : ST_WAIT;
        end
      end
      ST_HALT: begin
        if (!halt_req) w_state_next = ST_WAIT;
      end
      default: w_state_next = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_WAIT;
      r_micro_addr <= RESET_ADDR;
      r_halted     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_micro_addr <= w_addr_next;
      r_halted     <= (w_state_next == ST_HALT);
    end
  end

`ifdef MICRO_SEQ_PERF_EN
  logic [15:0] r_ucycle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ucycle_cnt <= 16'd0;
    end else if (w_fire && r_ucycle_cnt != 16'hFFFF) begin
      r_ucycle_cnt <= r_ucycle_cnt + 16'd1;
    end
  end

  assign ucycle_cnt = r_ucycle_cnt;
`else
  assign ucycle_cnt = 16'd0;
`endif

  assign micro_addr = r_micro_addr;
  assign op_fire    = w_fire;
  assign stall      = w_stall;
  assign ir_ack     = w_ack;
  assign halted     = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_micro_sequencer
// Brief    : Directed self-checking bench for micro_sequencer.
// Revision : 1.0
// ============================================================================
module tb_micro_sequencer;

  logic        clk;
  logic        rst_n;
  logic [5:0]  next_addr;
  logic [1:0]  br_sel;
  logic        cond_flag;
  logic [3:0]  ir_op;
  logic        ir_valid;
  logic        mem_wait;
  logic        halt_req;
  logic [5:0]  micro_addr;
  logic        op_fire;
  logic        ir_ack;
  logic        stall;
  logic        halted;
  logic [15:0] ucycle_cnt;

  int n_total;
  int n_bad;
  int exp_fires;

  micro_sequencer #(
    .RESET_ADDR   (6'd0),
    .FETCH_ADDR   (6'd1),
    .DISPATCH_BASE(6'd16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .next_addr (next_addr),
    .br_sel    (br_sel),
    .cond_flag (cond_flag),
    .ir_op     (ir_op),
    .ir_valid  (ir_valid),
    .mem_wait  (mem_wait),
    .halt_req  (halt_req),
    .micro_addr(micro_addr),
    .op_fire   (op_fire),
    .ir_ack    (ir_ack),
    .stall     (stall),
    .halted    (halted),
    .ucycle_cnt(ucycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt();
`ifdef MICRO_SEQ_PERF_EN
    return exp_fires[15:0];
`else
    return 16'd0;
`endif
  endfunction

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Called in WAIT: runs one non-stalling word through EVAL and checks the new address.
  task automatic run_word(input string tag, input logic [1:0] bs, input logic [5:0] na,
                          input logic cf, input logic [5:0] exp_addr);
    br_sel    = bs;
    next_addr = na;
    cond_flag = cf;
    cyc();
    check_val({tag, "_fire"}, {31'd0, op_fire}, 32'd1);
    exp_fires++;
    cyc();
    check_val({tag, "_addr"}, {26'd0, micro_addr}, {26'd0, exp_addr});
    check_val({tag, "_cnt"}, {16'd0, ucycle_cnt}, {16'd0, exp_cnt()});
  endtask

  initial begin
    n_total = 0; n_bad = 0; exp_fires = 0;
    rst_n = 1'b0; next_addr = '0; br_sel = '0; cond_flag = 1'b0;
    ir_op = '0; ir_valid = 1'b0; mem_wait = 1'b0; halt_req = 1'b0;
    repeat (2) cyc();
    check_val("rst_addr",   {26'd0, micro_addr}, 32'd0);
    check_val("rst_fire",   {31'd0, op_fire},    32'd0);
    check_val("rst_stall",  {31'd0, stall},      32'd0);
    check_val("rst_halted", {31'd0, halted},     32'd0);
    check_val("rst_cnt",    {16'd0, ucycle_cnt}, 32'd0);

    rst_n = 1'b1;
    // First cycle after release is WAIT: no fire yet.
    br_sel = 2'b00; next_addr = 6'd5;
    #1 check_val("wait_nofire", {31'd0, op_fire}, 32'd0);
    run_word("jmp5",  2'b00, 6'd5,  1'b0, 6'd5);
    run_word("jmp9",  2'b00, 6'd9,  1'b0, 6'd9);

    // COND at 12 taken / not taken, and wrap at 63
    run_word("to12a", 2'b00, 6'd12, 1'b0, 6'd12);
    run_word("condT", 2'b10, 6'd3,  1'b1, 6'd3);
    run_word("to12b", 2'b00, 6'd12, 1'b0, 6'd12);
    run_word("condF", 2'b10, 6'd3,  1'b0, 6'd13);
    run_word("to63",  2'b00, 6'd63, 1'b0, 6'd63);
    run_word("condW", 2'b10, 6'd3,  1'b0, 6'd0);
    run_word("fetch", 2'b11, 6'd40, 1'b0, 6'd1);

    // DISPATCH with ir_valid held low for three EVAL cycles
    br_sel = 2'b01; ir_op = 4'd7; ir_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_val("dsp_stall", {31'd0, stall},   32'd1);
      check_val("dsp_noack", {31'd0, ir_ack},  32'd0);
      check_val("dsp_nofire",{31'd0, op_fire}, 32'd0);
    end
    ir_valid = 1'b1;
    #1;
    check_val("dsp_ack",  {31'd0, ir_ack},  32'd1);
    check_val("dsp_fire", {31'd0, op_fire}, 32'd1);
    check_val("dsp_nostall", {31'd0, stall}, 32'd0);
    exp_fires++;
    cyc();
    ir_valid = 1'b0;
    check_val("dsp_addr", {26'd0, micro_addr}, 32'd23);
    check_val("dsp_ackdrop", {31'd0, ir_ack}, 32'd0);

    // mem_wait blocks a ready dispatch
    br_sel = 2'b01; ir_op = 4'd2; ir_valid = 1'b1; mem_wait = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check_val("mw_stall", {31'd0, stall},  32'd1);
      check_val("mw_noack", {31'd0, ir_ack}, 32'd0);
    end
    mem_wait = 1'b0;
    #1;
    check_val("mw_ack",  {31'd0, ir_ack},  32'd1);
    check_val("mw_fire", {31'd0, op_fire}, 32'd1);
    exp_fires++;
    cyc();
    ir_valid = 1'b0;
    check_val("mw_addr", {26'd0, micro_addr}, 32'd18);
    check_val("mw_single_ack", {31'd0, ir_ack}, 32'd0);
    check_val("mw_cnt", {16'd0, ucycle_cnt}, {16'd0, exp_cnt()});

    // halt after a JMP to 10
    br_sel = 2'b00; next_addr = 6'd10; halt_req = 1'b1;
    cyc();
    check_val("hlt_fire", {31'd0, op_fire}, 32'd1);
    exp_fires++;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_val("hlt_halted", {31'd0, halted},     32'd1);
      check_val("hlt_hold",   {26'd0, micro_addr}, 32'd10);
      check_val("hlt_nofire", {31'd0, op_fire},    32'd0);
    end
    halt_req = 1'b0;
    next_addr = 6'd20;
    cyc();
    check_val("resume_halted", {31'd0, halted},  32'd0);
    check_val("resume_wait",   {31'd0, op_fire}, 32'd0);
    cyc();
    check_val("resume_fire", {31'd0, op_fire},    32'd1);
    check_val("resume_addr", {26'd0, micro_addr}, 32'd10);
    exp_fires++;
    cyc();
    check_val("resume_next", {26'd0, micro_addr}, 32'd20);
    check_val("resume_cnt",  {16'd0, ucycle_cnt}, {16'd0, exp_cnt()});

    // async reset while stalled in EVAL
    mem_wait = 1'b1;
    cyc();
    check_val("pre_rst_stall", {31'd0, stall}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_addr",   {26'd0, micro_addr}, 32'd0);
    check_val("arst_halted", {31'd0, halted},     32'd0);
    check_val("arst_fire",   {31'd0, op_fire},    32'd0);
    check_val("arst_stall",  {31'd0, stall},      32'd0);
    check_val("arst_cnt",    {16'd0, ucycle_cnt}, 32'd0);
    mem_wait = 1'b0;
    cyc();
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/micro_sequencer.md
# micro_sequencer

- Microprogram sequencer that drives the 6-bit `micro_addr` of the registered micro-ROM and decides the next micro-address from the current microword.
- Uses the microword's next-address field, branch-select bits, the instruction-register opcode, a condition flag and memory/halt handshakes.
- Sits between the micro-ROM, the instruction register and the datapath control decode.
- Tells the datapath exactly which cycle a microword is committed.

## Interface
Parameters:
- RESET_ADDR, 6'd0, micro-address issued out of reset
- FETCH_ADDR, 6'd1, target of br_sel=11 (return to fetch)
- DISPATCH_BASE, 6'd16, base of the opcode dispatch table

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- next_addr  in  6  next-address field of the current microword (micro_op[5:0])
- br_sel  in  2  branch mode of the current microword: 00 JMP, 01 DISPATCH, 10 COND, 11 FETCH
- cond_flag  in  1  condition for COND (e.g. ALU zero), sampled on the fire edge
- ir_op  in  4  opcode from the instruction register
- ir_valid  in  1  ir_op is valid
- mem_wait  in  1  datapath/memory not ready; blocks commit
- halt_req  in  1  level request to stop after the current microword
- micro_addr  out  6  registered address to the micro-ROM
- op_fire  out  1  current microword commits this cycle
- ir_ack  out  1  one-cycle pulse when a dispatch consumes ir_op
- stall  out  1  in EVAL but blocked (mem_wait, or dispatch without ir_valid)
- halted  out  1  sequencer is in HALT
- ucycle_cnt  out  16  committed-microword counter (see Configuration)

## Operation
- FSM states: WAIT, EVAL, HALT. Reset: state=WAIT, micro_addr=RESET_ADDR, all 1-bit outputs 0, ucycle_cnt=0.
- WAIT: the ROM registers the word for micro_addr. Next state is EVAL unconditionally.
- EVAL: the microword is valid. Commit conditions are evaluated in priority order:
  - mem_wait=1: stall=1, op_fire=0, remain in EVAL.
  - br_sel=01 and ir_valid=0: stall=1, op_fire=0, remain in EVAL.
  - Otherwise op_fire=1 and micro_addr loads the next address (below). Next state is HALT if halt_req=1, else WAIT.
- Next-address rules (6-bit arithmetic, wrap modulo 64):
  - JMP: next_addr.
  - DISPATCH: DISPATCH_BASE + ir_op, with ir_ack=1 in the fire cycle.
  - COND: next_addr if cond_flag=1, else micro_addr+1. 6'd63+1 wraps to 6'd0.
  - FETCH: FETCH_ADDR.
- HALT: halted=1 and micro_addr holds. When halt_req=0 is sampled, the next state is WAIT (halted drops on that edge). The held address is then re-read and executed normally.
- halt_req is ignored in EVAL until the word fires. A halt request never aborts a stalled microword.
- ir_ack is only ever asserted together with op_fire and br_sel=01.
- Asynchronous reset in any state returns to WAIT/RESET_ADDR immediately. No pending ack or fire survives.

## Timing
- Throughput: 2 cycles per microword minimum (WAIT + EVAL). Each stall cycle adds 1.
- Address latency:
  - micro_addr changes on edge T.
  - The ROM output is valid after edge T+1.
  - op_fire is asserted in the cycle following T+1.
  - The next micro_addr appears on edge T+2.
- Outputs are combinational from state plus inputs: op_fire, stall, ir_ack.
- Outputs are registered: micro_addr, halted, ucycle_cnt.
- First op_fire after reset release: in the 2nd cycle after release.

## Configuration
- MICRO_SEQ_PERF_EN defined:
  - ucycle_cnt increments by 1 on every op_fire.
  - It saturates at 16'hFFFF and clears only on reset.
- MICRO_SEQ_PERF_EN undefined: ucycle_cnt is constant 16'd0 and no counter flops are synthesized.

## Test plan
- Reset then free-run JMP chain 0→5→9 (next_addr fields 5, 9): micro_addr sequence 0,5,9. op_fire pulses every 2 cycles. ucycle_cnt=2 after the second fire (PERF_EN).
- COND at addr 12, next_addr=3:
  - cond_flag=1 → micro_addr=3.
  - Repeat with cond_flag=0 → 13.
  - COND at 63 with cond_flag=0 → 0.
- DISPATCH, ir_op=4'd7, ir_valid low for 3 EVAL cycles: stall=1 for 3 cycles, no ir_ack. Then ir_valid=1 → ir_ack=1 and op_fire=1 in the same cycle, micro_addr=23.
- mem_wait=1 together with ir_valid=1 on a dispatch word: stall=1, ir_ack=0 until mem_wait=0, then a single ir_ack pulse.
- halt_req=1 during a JMP to 10: fire, halted=1 next edge, micro_addr holds 10 for 5 cycles. halt_req=0 → WAIT, then EVAL of word 10 with op_fire=1.
- rst_n asserted mid-EVAL with stall=1: micro_addr=RESET_ADDR, halted=0, op_fire=0, ucycle_cnt=0 immediately. Repeat without MICRO_SEQ_PERF_EN: ucycle_cnt is always 0.
